// File: rtl/wb_arb_pkg.sv
// Shared definitions for the three-master Wishbone round-robin arbiter:
// master count, FSM state encoding and the post-reset priority pointer.
package wb_arb_pkg;

  localparam int N_MASTERS = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  // Pointer starts on the last master so master 0 wins the first search.
  localparam logic [N_MASTERS-1:0] RESET_LAST = 3'b100;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin search: first requester above the one-hot
// last grant, wrapping around; gnt is one-hot, or zero if nobody requests.
module wb_rr_pick
  import wb_arb_pkg::*;
(
  input  logic [N_MASTERS-1:0] req,
  input  logic [N_MASTERS-1:0] last,
  output logic [N_MASTERS-1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (last)
      3'b001:  gnt = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
      3'b010:  gnt = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
      default: gnt = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
    endcase
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Three-master Wishbone round-robin arbiter with a per-cycle watchdog that
// aborts a stalled slave access with err to the owner, then drains the cycle.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int aw      = 32,
  parameter int dw      = 32,
  parameter int timeout = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  input  logic [N_MASTERS*aw-1:0] wbm_adr_i,
  input  logic [N_MASTERS*dw-1:0] wbm_dat_i,
  input  logic [N_MASTERS*4-1:0]  wbm_sel_i,
  input  logic [N_MASTERS-1:0]    wbm_we_i,
  input  logic [N_MASTERS-1:0]    wbm_cyc_i,
  input  logic [N_MASTERS-1:0]    wbm_stb_i,
  input  logic [N_MASTERS*3-1:0]  wbm_cti_i,
  input  logic [N_MASTERS*2-1:0]  wbm_bte_i,
  output logic [N_MASTERS*dw-1:0] wbm_dat_o,
  output logic [N_MASTERS-1:0]    wbm_ack_o,
  output logic [N_MASTERS-1:0]    wbm_err_o,
  output logic [N_MASTERS-1:0]    wbm_rty_o,
  output logic [aw-1:0]           wbs_adr_o,
  output logic [dw-1:0]           wbs_dat_o,
  output logic [3:0]              wbs_sel_o,
  output logic                    wbs_we_o,
  output logic                    wbs_cyc_o,
  output logic                    wbs_stb_o,
  output logic [2:0]              wbs_cti_o,
  output logic [1:0]              wbs_bte_o,
  input  logic [dw-1:0]           wbs_dat_i,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  input  logic                    wbs_rty_i,
  output logic [N_MASTERS-1:0]    grant_o,
  output logic                    timeout_o
);

  localparam int CW = (timeout > 0) ? $clog2(timeout + 1) : 1;

  arb_state_e           state_q;
  logic [N_MASTERS-1:0] grant_q;
  logic [N_MASTERS-1:0] last_q;
  logic [N_MASTERS-1:0] pick_gnt;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_inc;
  logic                 timeout_q;
  logic                 own_cyc;
  logic                 own_stb;
  logic                 slv_resp;
  logic                 busy;
  logic                 abort;

  wb_rr_pick u_pick (
    .req  (wbm_cyc_i),
    .last (last_q),
    .gnt  (pick_gnt)
  );

  // Request path: AND-OR mux on the one-hot grant, all zero with no owner.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (grant_q[k]) begin
        wbs_adr_o = wbm_adr_i[k*aw +: aw];
        wbs_dat_o = wbm_dat_i[k*dw +: dw];
        wbs_sel_o = wbm_sel_i[k*4 +: 4];
        wbs_we_o  = wbm_we_i[k];
        wbs_cti_o = wbm_cti_i[k*3 +: 3];
        wbs_bte_o = wbm_bte_i[k*2 +: 2];
      end
    end
  end

  assign own_cyc  = |(grant_q & wbm_cyc_i);
  assign own_stb  = |(grant_q & wbm_stb_i);
  assign busy     = (state_q == ST_BUSY);
  assign abort    = (state_q == ST_ABORT);
  assign slv_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign cnt_inc  = cnt_q + CW'(1);

  assign wbs_cyc_o = busy & own_cyc;
  assign wbs_stb_o = busy & own_stb;

  // Responses outside BUSY are dropped; ABORT forces err to the owner.
  assign wbm_ack_o = grant_q & {N_MASTERS{busy & wbs_ack_i}};
  assign wbm_err_o = grant_q & {N_MASTERS{(busy & wbs_err_i) | abort}};
  assign wbm_rty_o = grant_q & {N_MASTERS{busy & wbs_rty_i}};
  assign wbm_dat_o = {N_MASTERS{wbs_dat_i}};

  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      last_q    <= RESET_LAST;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|wbm_cyc_i) begin
            grant_q <= pick_gnt;
            last_q  <= pick_gnt;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!own_cyc) begin
            // Owner released: hand over in this same edge or fall idle.
            grant_q <= pick_gnt;
            if (|pick_gnt) last_q <= pick_gnt;
            else state_q <= ST_IDLE;
          end else if (!slv_resp && own_stb && (timeout != 0)) begin
            if (cnt_inc == CW'(timeout)) begin
              state_q   <= ST_ABORT;
              timeout_q <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        ST_ABORT: state_q <= ST_DRAIN;
        ST_DRAIN: begin
          if (!own_cyc) begin
            grant_q <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios then randomized traffic, all
// compared each cycle against a transaction-level owner/priority model.
module tb_wb_rr_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  localparam int M_IDLE  = 0;
  localparam int M_BUSY  = 1;
  localparam int M_ABORT = 2;
  localparam int M_DRAIN = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3*AW-1:0] m_adr;
  logic [3*DW-1:0] m_dat;
  logic [11:0]     m_sel;
  logic [2:0]      m_we, m_cyc, m_stb;
  logic [8:0]      m_cti;
  logic [5:0]      m_bte;
  logic [3*DW-1:0] wbm_dat;
  logic [2:0]      wbm_ack, wbm_err, wbm_rty;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_o;
  logic [3:0]      s_sel;
  logic            s_we, s_cyc, s_stb;
  logic [2:0]      s_cti;
  logic [1:0]      s_bte;
  logic [DW-1:0]   s_dat;
  logic            s_ack, s_err, s_rty;
  logic [2:0]      grant;
  logic            tmo;

  int checks = 0;
  int errors = 0;

  int md_mode, md_owner, md_last, md_cnt;

  wb_rr_arbiter #(.aw(AW), .dw(DW), .timeout(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
    .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
    .wbm_dat_o(wbm_dat), .wbm_ack_o(wbm_ack), .wbm_err_o(wbm_err), .wbm_rty_o(wbm_rty),
    .wbs_adr_o(s_adr), .wbs_dat_o(s_dat_o), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
    .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_cti_o(s_cti), .wbs_bte_o(s_bte),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .grant_o(grant), .timeout_o(tmo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int search(input logic [2:0] req, input int last);
    for (int off = 1; off <= 3; off++) begin
      int idx;
      idx = (last + off) % 3;
      if (req[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    md_mode = M_IDLE; md_owner = -1; md_last = 2; md_cnt = 0;
  endtask

  task automatic model_edge();
    int w;
    logic oc, os;
    oc = 1'b0; os = 1'b0;
    if (md_owner >= 0) begin
      oc = m_cyc[md_owner[1:0]];
      os = m_stb[md_owner[1:0]];
    end
    case (md_mode)
      M_IDLE: begin
        md_cnt = 0;
        w = search(m_cyc, md_last);
        if (w >= 0) begin md_owner = w; md_last = w; md_mode = M_BUSY; end
      end
      M_BUSY: begin
        if (!oc) begin
          md_cnt = 0;
          w = search(m_cyc, md_last);
          if (w >= 0) begin md_owner = w; md_last = w; end
          else begin md_owner = -1; md_mode = M_IDLE; end
        end else if (s_ack || s_err || s_rty || !os) begin
          md_cnt = 0;
        end else begin
          md_cnt++;
          if (md_cnt == TMO) begin md_mode = M_ABORT; md_cnt = 0; end
        end
      end
      M_ABORT: md_mode = M_DRAIN;
      default: if (!oc) begin md_mode = M_IDLE; md_owner = -1; end
    endcase
  endtask

  task automatic check_all(input string ph);
    logic [2:0] eg;
    logic busy, abort, oc, os, owe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    eg = 3'b000; oc = 1'b0; os = 1'b0; owe = 1'b0; ea = '0; ed = '0;
    if (md_owner >= 0) begin
      eg  = 3'b001 << md_owner;
      oc  = m_cyc[md_owner[1:0]];
      os  = m_stb[md_owner[1:0]];
      owe = m_we[md_owner[1:0]];
      ea  = m_adr[md_owner*AW +: AW];
      ed  = m_dat[md_owner*DW +: DW];
    end
    busy  = (md_mode == M_BUSY);
    abort = (md_mode == M_ABORT);
    chk({ph, "_grant"}, grant, eg);
    chk({ph, "_wbs_cyc"}, s_cyc, busy & oc);
    chk({ph, "_wbs_stb"}, s_stb, busy & os);
    chk({ph, "_wbs_adr"}, s_adr, ea);
    chk({ph, "_wbs_dat"}, s_dat_o, ed);
    chk({ph, "_wbs_we"}, s_we, owe);
    chk({ph, "_ack"}, wbm_ack, (busy && s_ack) ? eg : 3'b000);
    chk({ph, "_err"}, wbm_err, ((busy && s_err) || abort) ? eg : 3'b000);
    chk({ph, "_rty"}, wbm_rty, (busy && s_rty) ? eg : 3'b000);
    chk({ph, "_dat2"}, wbm_dat[2*DW +: DW], s_dat);
    chk({ph, "_timeout"}, tmo, abort);
  endtask

  task automatic cycle(input string ph);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all(ph);
  endtask

  task automatic settle(input string ph);
    #1;
    check_all(ph);
  endtask

  initial begin
    rst_n = 1'b0;
    m_adr = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    m_dat = {32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    m_sel = 12'hFFF; m_we = 3'b000; m_cyc = 3'b000; m_stb = 3'b000;
    m_cti = '0; m_bte = '0;
    s_dat = 32'h5A5A_0001; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset_grant", grant, 3'b000);
    chk("reset_timeout", tmo, 1'b0);

    // Rotation with all three masters requesting.
    m_cyc = 3'b111;
    rst_n = 1'b1;
    cycle("rr1");  chk("rr_first", grant, 3'b001);
    m_cyc = 3'b110; cycle("rr2"); chk("rr_second", grant, 3'b010);
    m_cyc = 3'b111; cycle("rr3"); chk("rr_hold", grant, 3'b010);
    m_cyc = 3'b101; cycle("rr4"); chk("rr_third", grant, 3'b100);
    m_cyc = 3'b111; cycle("rr5");
    m_cyc = 3'b011; cycle("rr6"); chk("rr_wrap", grant, 3'b001);
    m_cyc = 3'b000; cycle("rr7"); chk("rr_idle", grant, 3'b000);

    // Master 1 burst while master 0 waits.
    m_cyc = 3'b011; m_stb = 3'b011; m_cti[3 +: 3] = 3'd2;
    cycle("bs0"); chk("burst_grant", grant, 3'b010);
    for (int b = 0; b < 4; b++) begin
      s_ack = 1'b1;
      m_cti[3 +: 3] = (b == 3) ? 3'd7 : 3'd2;
      s_dat = 32'hB000_0000 + b;
      settle("bsa");
      chk("burst_ack", wbm_ack, 3'b010);
      chk("burst_adr", s_adr, 32'hA000_0001);
      chk("burst_cti", s_cti, (b == 3) ? 3'd7 : 3'd2);
      cycle("bsb");
      chk("burst_hold", grant, 3'b010);
    end
    s_ack = 1'b0; m_cti = '0;
    m_cyc = 3'b001; m_stb = 3'b001;
    cycle("bs9"); chk("burst_handover", grant, 3'b001);

    // Ack on the fourth stalled clock wins over the watchdog.
    for (int i = 0; i < 3; i++) begin
      cycle("ta"); chk("tack_no_tmo", tmo, 1'b0);
    end
    s_ack = 1'b1; settle("tb"); chk("tack_ack", wbm_ack, 3'b001);
    cycle("tc");
    chk("tack_tmo", tmo, 1'b0); chk("tack_err", wbm_err, 3'b000);
    s_ack = 1'b0;

    // Slave never answers: abort then drain.
    for (int i = 0; i < 3; i++) begin
      cycle("wa"); chk("wd_pre", tmo, 1'b0);
    end
    cycle("wb");
    chk("wd_tmo", tmo, 1'b1); chk("wd_err", wbm_err, 3'b001); chk("wd_cyc", s_cyc, 1'b0);
    s_ack = 1'b1; settle("wc"); chk("wd_ack_drop", wbm_ack, 3'b000);
    cycle("wd");
    chk("wd_tmo_pulse", tmo, 1'b0); chk("wd_err_pulse", wbm_err, 3'b000);
    s_ack = 1'b0;
    cycle("we"); chk("wd_drain_grant", grant, 3'b001);
    m_cyc = 3'b000; m_stb = 3'b000;
    cycle("wf"); chk("wd_idle", grant, 3'b000);

    // Reset dropped mid-burst on master 2.
    m_cyc = 3'b100; m_stb = 3'b100; m_cti[6 +: 3] = 3'd2;
    cycle("ra"); chk("rst_pre_grant", grant, 3'b100);
    s_ack = 1'b1; cycle("rb");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rc");
    chk("rst_cyc", s_cyc, 1'b0); chk("rst_grant", grant, 3'b000); chk("rst_ack", wbm_ack, 3'b000);
    @(posedge clk);
    #1;
    rst_n = 1'b1; s_ack = 1'b0; m_cti = '0;
    m_cyc = 3'b111; m_stb = 3'b000;
    cycle("rd"); chk("rst_first", grant, 3'b001);
    m_cyc = 3'b000;
    cycle("re");

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      int r;
      for (int k = 0; k < 3; k++) begin
        if ($urandom % 6 == 0) m_cyc[k] = ~m_cyc[k];
        m_stb[k] = m_cyc[k] & ($urandom % 3 != 0);
        m_we[k]  = $urandom % 2 == 0;
      end
      m_adr = {$urandom, $urandom, $urandom};
      m_dat = {$urandom, $urandom, $urandom};
      m_sel = 12'($urandom); m_cti = 9'($urandom); m_bte = 6'($urandom);
      r = $urandom % 10;
      s_ack = (r < 3); s_err = (r == 3); s_rty = (r == 4);
      s_dat = $urandom;
      settle("rnd_c");
      cycle("rnd_e");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 Parameter aw, default 32, Wishbone address width.
REQ-002 Parameter dw, default 32, Wishbone data width.
REQ-003 Parameter timeout, default 255, bus-cycle watchdog limit in clocks; 0 disables the watchdog.
REQ-004 Port wb_clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-005 Port wb_rst_n_i, input, 1, reset; asynchronous assert, active-low.
REQ-006 Ports wbm_adr_i/dat_i/sel_i/we_i/cyc_i/stb_i/cti_i/bte_i, inputs, 3*aw/3*dw/12/3/3/3/9/6, three masters packed, master k in slice k.
REQ-007 Ports wbm_dat_o/ack_o/err_o/rty_o, outputs, 3*dw/3/3/3, per-master responses, packed the same way.
REQ-008 Ports wbs_adr_o/dat_o/sel_o/we_o/cyc_o/stb_o/cti_o/bte_o, outputs, aw/dw/4/1/1/1/3/2, shared slave request.
REQ-009 Ports wbs_dat_i/ack_i/err_i/rty_i, inputs, dw/1/1/1, slave response.
REQ-010 Port grant_o, output, 3, one-hot current owner; 0 when no owner.
REQ-011 Port timeout_o, output, 1, one-cycle pulse when the watchdog fires.

Function
REQ-012 The FSM SHALL have states IDLE, BUSY, ABORT and DRAIN.
REQ-013 In IDLE, with any wbm_cyc_i[k] high at a clock edge, the arbiter SHALL register a grant and enter BUSY; arbitration latency is exactly 1 clock.
REQ-014 The winner SHALL be the first requester searched from (last_grant+1) mod 3 upward with wrap-around (round-robin).
REQ-015 In BUSY, slave request outputs SHALL equal the granted master's inputs combinationally; wbs_cyc_o and wbs_stb_o SHALL be 0 outside BUSY.
REQ-016 wbm_ack_o/err_o/rty_o SHALL pass slave responses to the granted master only; non-granted masters see 0; wbs_dat_i SHALL be broadcast on every wbm_dat_o slice.
REQ-017 The grant SHALL be held while the owner's cyc_i is high, including across bursts (cti_i != 0) and stb_i low gaps.
REQ-018 When the owner's cyc_i is low at an edge in BUSY, the arbiter SHALL re-arbitrate in that same edge: grant the next requester and stay in BUSY, or go to IDLE if none.
REQ-019 The watchdog counter SHALL clear on any of ack/err/rty, while stb_i is low, and outside BUSY, and increment each BUSY clock with the owner's stb_i high.
REQ-020 When the counter reaches timeout (timeout != 0), the FSM SHALL enter ABORT; that state lasts 1 clock.
REQ-021 In ABORT, the owner's err_o SHALL be 1, timeout_o SHALL be 1, and slave cyc/stb SHALL be 0.
REQ-022 From ABORT, the FSM SHALL go to DRAIN; it SHALL stay in DRAIN until the owner's cyc_i is low, then go to IDLE.
REQ-023 A slave response arriving in ABORT or DRAIN SHALL be discarded.
REQ-024 last_grant SHALL update only when a new grant is registered.
REQ-025 If ack_i arrives in the same cycle the counter reaches timeout, ack SHALL take precedence and no abort SHALL occur.
REQ-026 The counter width SHALL be clog2(timeout+1), with a minimum of 1.

Reset
REQ-027 While wb_rst_n_i is low: state SHALL be IDLE, grant_o 3'b000, last_grant master 2 (so master 0 wins first), counter 0, and timeout_o 0.
REQ-028 Reset asserted mid-cycle SHALL drop wbs_cyc_o/stb_o and every wbm ack/err/rty to 0 immediately, without waiting for a clock.
REQ-029 Release of wb_rst_n_i SHALL be sampled on wb_clk_i; the first grant can be registered on the first edge after release.

Structure
REQ-030 FSM state encodings and the master count (3) SHALL reside in shared package wb_arb_pkg.
REQ-031 The round-robin search SHALL be one combinational sub-module, wb_rr_pick (inputs req[2:0] and last[2:0]; output one-hot gnt[2:0]).

Verification
REQ-032 Reset release with all three cyc_i high -> grant_o sequence 001, 010, 100, 001 as each owner drops cyc_i for 1 clock.
REQ-033 Master 1 runs a 4-beat burst (cti_i=2, then 7) while master 0 requests -> grant_o stays 010 for all 4 acks; master 0 is granted on the edge after master 1 drops cyc_i.
REQ-034 timeout=4, slave never acks -> after 4 stb_i-high clocks: one err_o pulse to the owner, timeout_o=1 for 1 clock, wbs_cyc_o=0; state is IDLE after the owner drops cyc_i.
REQ-035 timeout=4, ack_i arrives on the 4th clock -> normal ack, no err_o, no timeout_o.
REQ-036 wb_rst_n_i pulled low mid-burst -> wbs_cyc_o=0 and grant_o=000 before the next edge; after release, master 0 has first priority.
REQ-037 Non-granted master asserts cyc_i/stb_i -> its ack_o stays 0 and its address never appears on wbs_adr_o.
